mario_sprite_renderer: RTL and testbench
========================================

Name: mario_sprite_renderer

Overview:
- Pixel-pipeline stage directly downstream of the 16x16 Mario character ROM.
- Takes the current VGA draw coordinate and Mario's position, then drives the ROM address.
- Chroma-keys the returned 24-bit RGB against the background pixel and outputs the composited colour.
- Adds per-frame position latching, horizontal mirroring, integer scaling and a two-phase walk animation select.

Parameters:
- SCALE_LOG2, 1, on-screen magnification as a power of two (0 gives 16x16, 1 gives 32x32, 2 gives 64x64).
- ANIM_FRAMES, 8, vsync frames per walk-phase toggle; legal range 1..255.
- KEY_RGB, 24'hFFD700, transparent colour in the ROM data.

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse at the start of vertical blank
- pix_valid_in  in  1  DrawX/DrawY/bg_rgb are a visible pixel this cycle
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- bg_rgb  in  24  background colour for this pixel
- mario_x  in  10  sprite top-left column (live, game logic)
- mario_y  in  10  sprite top-left row (live)
- facing_left  in  1  1 = left-facing (native ROM orientation), 0 = mirrored
- moving  in  1  1 = walk animation enabled
- rom_addr  out  8  address to character ROM (combinational ROM, same-cycle data)
- rom_sel  out  1  walk phase; selects between the two ROM variants externally
- rom_rgb  in  24  ROM data for rom_addr
- rgb_out  out  24  composited pixel
- pix_valid_out  out  1  rgb_out is valid
- sprite_hit_out  out  1  rgb_out came from an opaque sprite texel

Behaviour:
- Reset (async, Reset_n=0): clear all registers.
  - rgb_out=0, pix_valid_out=0, sprite_hit_out=0, rom_addr=0, rom_sel=0.
  - Shadow position = (0,0), shadow facing = 1, anim counter = 0.
- Shadow latch:
  - On frame_start=1, capture mario_x, mario_y, facing_left into shadow registers.
  - Between frame_start pulses, render only from the shadow registers, so there is no tearing.
  - A frame_start in the same cycle as a visible pixel: that pixel uses the old shadow; the new values apply from the next cycle.
- Stage 1 (registered at edge 1):
  - dx = {1'b0,DrawX} - {1'b0,sx} and dy likewise, using 11-bit arithmetic.
  - hit = pix_valid_in, dx[10]=0, dx < (16<<SCALE_LOG2), dy[10]=0, and dy < (16<<SCALE_LOG2).
  - Off-screen edges clip naturally; there is no wrap-around.
  - row = dy[SCALE_LOG2+3:SCALE_LOG2]; col = dx[SCALE_LOG2+3:SCALE_LOG2].
  - If shadow facing = 0, col is replaced by 15-col.
  - ROM storage is reverse raster: top-left texel is address 255, bottom-right is 0. rom_addr = ~{row,col}.
  - Register hit, rom_addr, bg_rgb and pix_valid_in.
  - rom_addr holds its last value when hit=0 (don't-care to ROM).
- Stage 2 (registered at edge 2):
  - opaque = hit1 && (rom_rgb != KEY_RGB). Exact 24-bit compare; near-key colours (e.g. FFCD72) are opaque.
  - rgb_out = opaque ? rom_rgb : bg1.
  - sprite_hit_out = opaque; pix_valid_out = valid1.
  - When valid1=0, rgb_out = 0.
- Latency: exactly 2 Clk from pix_valid_in/DrawX to rgb_out. Throughput is 1 pixel/clk, with no stalls.
- Animation:
  - An 8-bit counter advances on each frame_start while moving=1.
  - At ANIM_FRAMES-1 the counter wraps to 0 and rom_sel toggles.
  - If moving=0 at a frame_start, the counter clears and rom_sel goes to 0 on that edge.
  - moving changes between frame_start pulses have no effect until the next pulse.
- Reset mid-line: the pipeline flushes immediately. The first valid output appears 2 clocks after the first post-reset pix_valid_in.

Decomposition:
- Shared package `mario_pkg`:
  - Constants SPRITE_DIM=16, KEY_RGB default, SCREEN_W=640, SCREEN_H=480.
  - Typedef rgb_t (logic [23:0]).
  - Typedef coord_t (logic [9:0]).
- One natural sub-module: `sprite_anim_ctr`, holding the frame counter and rom_sel logic.
- The remaining logic is a flat two-stage pipeline.

Test Plan:
- Mapping: reset, frame_start with mario=(100,50), facing_left=1, SCALE_LOG2=1. Pixel (100,50) -> rom_addr=255 one cycle later; pixel (131,81) -> rom_addr=0.
- Transparency: hit pixel with ROM returning FFD700 and bg=00FF00 -> rgb_out=00FF00, sprite_hit_out=0. ROM returning FF0000 -> rgb_out=FF0000, sprite_hit_out=1, exactly 2 clocks after input.
- Mirroring: facing_left=0 latched, pixel (100,50) -> rom_addr=~{4'd0,4'd15}=240.
- Edge clipping: mario_x=630, pixel (639,60) -> hit; DrawX=0 on the next line -> no hit, rgb_out=bg. mario_y=470 -> rows 470..479 drawn only.
- Shadow latch: change mario_x mid-frame from 100 to 200 -> pixels at 100 are still drawn until the next frame_start, then at 200.
- Animation/reset: moving=1, ANIM_FRAMES=8 -> rom_sel toggles every 8th frame_start. Drop moving -> rom_sel=0 at the next pulse. Assert Reset_n=0 mid-line -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mario_pkg.sv
// Shared types and constants for the Mario sprite pixel pipeline.
package mario_pkg;

  localparam int          SPRITE_DIM   = 16;
  localparam int          SCREEN_W     = 640;
  localparam int          SCREEN_H     = 480;
  localparam logic [23:0] KEY_RGB_DFLT = 24'hFFD700;

  typedef logic [23:0] rgb_t;
  typedef logic [9:0]  coord_t;

  // The ROM is stored in reverse raster order, so the top-left texel sits at address 255.
  function automatic logic [7:0] tex_addr(input logic [3:0] row, input logic [3:0] col,
                                          input logic mirror);
    logic [3:0] c;
    c = mirror ? 4'(4'd15 - col) : col;
    return ~{row, c};
  endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Walk-animation phase generator: counts moving frames and toggles the ROM variant select.
module sprite_anim_ctr #(
  parameter int ANIM_FRAMES = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_start,
  input  logic moving,
  output logic rom_sel
);

  localparam logic [7:0] LAST = 8'(ANIM_FRAMES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (frame_start) begin
      if (!moving) begin
        cnt_d = '0;
        sel_d = 1'b0;
      end else if (cnt_q == LAST) begin
        cnt_d = '0;
        sel_d = ~sel_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
      sel_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign rom_sel = sel_q;

endmodule

// File: rtl/mario_sprite_renderer.sv
// Two-stage sprite compositor: maps the draw coordinate into the Mario ROM, then chroma-keys
// the returned texel over the background pixel.
module mario_sprite_renderer
  import mario_pkg::*;
#(
  parameter int   SCALE_LOG2  = 1,
  parameter int   ANIM_FRAMES = 8,
  parameter rgb_t KEY_RGB     = KEY_RGB_DFLT
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       pix_valid_in,
  input  coord_t     DrawX,
  input  coord_t     DrawY,
  input  rgb_t       bg_rgb,
  input  coord_t     mario_x,
  input  coord_t     mario_y,
  input  logic       facing_left,
  input  logic       moving,
  output logic [7:0] rom_addr,
  output logic       rom_sel,
  input  rgb_t       rom_rgb,
  output rgb_t       rgb_out,
  output logic       pix_valid_out,
  output logic       sprite_hit_out
);

  localparam logic [10:0] DIM_S = 11'(SPRITE_DIM << SCALE_LOG2);

  // Shadow copy of the sprite position, refreshed only at frame start to avoid tearing.
  coord_t sx_q, sy_q;
  logic   face_q;

  logic [7:0] addr_q;
  logic       hit1_q, valid1_q;
  rgb_t       bg1_q;
  rgb_t       rgb_q;
  logic       valid2_q, hit2_q;

  logic [10:0] dx, dy, dx_sh, dy_sh;
  logic        hit;
  logic        opaque;

  assign dx    = {1'b0, DrawX} - {1'b0, sx_q};
  assign dy    = {1'b0, DrawY} - {1'b0, sy_q};
  assign dx_sh = dx >> SCALE_LOG2;
  assign dy_sh = dy >> SCALE_LOG2;

  // A negative difference sets bit 10, so sprites hanging off the left/top clip instead of wrapping.
  assign hit = pix_valid_in && !dx[10] && (dx < DIM_S) && !dy[10] && (dy < DIM_S);

  // NOTE: the pixel data registers are reset too, so a mid-line reset flushes the pipeline at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx_q     <= '0;
      sy_q     <= '0;
      face_q   <= 1'b1;
      addr_q   <= '0;
      hit1_q   <= 1'b0;
      valid1_q <= 1'b0;
      bg1_q    <= '0;
    end else begin
      if (frame_start) begin
        sx_q   <= mario_x;
        sy_q   <= mario_y;
        face_q <= facing_left;
      end
      if (hit) addr_q <= tex_addr(dy_sh[3:0], dx_sh[3:0], !face_q);
      hit1_q   <= hit;
      valid1_q <= pix_valid_in;
      bg1_q    <= bg_rgb;
    end
  end

  assign opaque = hit1_q && (rom_rgb != KEY_RGB);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q    <= '0;
      valid2_q <= 1'b0;
      hit2_q   <= 1'b0;
    end else begin
      rgb_q    <= !valid1_q ? '0 : (opaque ? rom_rgb : bg1_q);
      valid2_q <= valid1_q;
      hit2_q   <= opaque;
    end
  end

  sprite_anim_ctr #(
    .ANIM_FRAMES(ANIM_FRAMES)
  ) u_anim (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_start(frame_start),
    .moving     (moving),
    .rom_sel    (rom_sel)
  );

  assign rom_addr       = addr_q;
  assign rgb_out        = rgb_q;
  assign pix_valid_out  = valid2_q;
  assign sprite_hit_out = hit2_q;

endmodule

// File: tb/tb_mario_sprite_renderer.sv
// Bench for mario_sprite_renderer: directed scenarios plus a random pixel stream, checked
// every cycle against a coordinate-arithmetic model of the sprite compositor.
module tb_mario_sprite_renderer;

  localparam int          S    = 1;
  localparam int          ANIM = 8;
  localparam int          DIM  = 16 << S;
  localparam logic [23:0] KEY  = 24'hFFD700;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0, pix_valid_in = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, mario_x = '0, mario_y = '0;
  logic [23:0] bg_rgb = '0;
  logic        facing_left = 1'b1, moving = 1'b0;
  logic [7:0]  rom_addr;
  logic        rom_sel;
  logic [23:0] rom_rgb, rgb_out;
  logic        pix_valid_out, sprite_hit_out;

  logic [23:0] rom_mem [2][256];
  assign rom_rgb = rom_mem[rom_sel][rom_addr];

  always #5 Clk = ~Clk;

  mario_sprite_renderer #(.SCALE_LOG2(S), .ANIM_FRAMES(ANIM), .KEY_RGB(KEY)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid_in(pix_valid_in),
    .DrawX(DrawX), .DrawY(DrawY), .bg_rgb(bg_rgb), .mario_x(mario_x), .mario_y(mario_y),
    .facing_left(facing_left), .moving(moving), .rom_addr(rom_addr), .rom_sel(rom_sel),
    .rom_rgb(rom_rgb), .rgb_out(rgb_out), .pix_valid_out(pix_valid_out),
    .sprite_hit_out(sprite_hit_out)
  );

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: plain coordinate arithmetic on a latched sprite position.
  int          m_sx = 0, m_sy = 0, m_run = 0;
  bit          m_face = 1'b1;
  logic [7:0]  m_addr = '0;
  bit          st_v = 0, st_h = 0, out_v = 0, out_h = 0;
  logic [23:0] st_rgb = '0, out_rgb = '0;

  always @(posedge Clk or negedge Reset_n) begin : model
    int          tx, ty, sel;
    bit          hit, opq;
    logic [23:0] texel;
    if (!Reset_n) begin
      m_sx = 0; m_sy = 0; m_face = 1'b1; m_run = 0; m_addr = '0;
      st_v = 0; st_h = 0; st_rgb = '0; out_v = 0; out_h = 0; out_rgb = '0;
    end else begin
      out_v = st_v; out_h = st_h; out_rgb = st_rgb;
      hit = pix_valid_in && (int'(DrawX) >= m_sx) && (int'(DrawX) < m_sx + DIM)
                         && (int'(DrawY) >= m_sy) && (int'(DrawY) < m_sy + DIM);
      if (hit) begin
        tx = (int'(DrawX) - m_sx) / (1 << S);
        ty = (int'(DrawY) - m_sy) / (1 << S);
        if (!m_face) tx = 15 - tx;
        m_addr = 8'(255 - (ty * 16 + tx));
      end
      if (frame_start) begin
        m_sx = int'(mario_x); m_sy = int'(mario_y); m_face = facing_left;
        m_run = moving ? m_run + 1 : 0;
      end
      sel   = (m_run / ANIM) % 2;
      texel = rom_mem[sel][m_addr];
      opq   = hit && (texel != KEY);
      st_v  = pix_valid_in;
      st_h  = opq;
      st_rgb = !pix_valid_in ? 24'h0 : (opq ? texel : bg_rgb);
    end
  end

  always @(negedge Clk) begin
    check("valid", 32'(pix_valid_out), 32'(out_v));
    check("rgb", 32'(rgb_out), 32'(out_rgb));
    check("sprite_hit", 32'(sprite_hit_out), 32'(out_h));
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("rom_sel", 32'(rom_sel), 32'((m_run / ANIM) % 2));
  end

  task automatic drive(input bit fs, input bit v, input int x, input int y,
                       input logic [23:0] bg);
    frame_start  = fs;
    pix_valid_in = v;
    DrawX        = 10'(x);
    DrawY        = 10'(y);
    bg_rgb       = bg;
    @(negedge Clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 24'h0);
  endtask

  initial begin
    int x, y, r;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) begin
        r = $urandom_range(0, 5);
        rom_mem[b][a] = (r == 0) ? KEY : (r == 1) ? 24'hFFCD72 : (r == 2) ? 24'hFFD701
                                                                       : 24'($urandom);
      end
    rom_mem[0][255] = KEY;
    rom_mem[0][0]   = 24'hFF0000;
    rom_mem[0][238] = 24'h0000FF;

    repeat (3) @(negedge Clk);
    check("rst_rgb", 32'(rgb_out), 32'h0);
    check("rst_valid", 32'(pix_valid_out), 32'h0);
    check("rst_sel", 32'(rom_sel), 32'h0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Mapping and transparency
    mario_x = 10'd100; mario_y = 10'd50; facing_left = 1'b1; moving = 1'b0;
    drive(1, 0, 0, 0, 24'h0);
    drive(0, 1, 100, 50, 24'h00FF00);
    check("map_top_left", 32'(rom_addr), 32'd255);
    drive(0, 1, 131, 81, 24'h00FF00);
    check("map_bot_right", 32'(rom_addr), 32'd0);
    check("key_rgb", 32'(rgb_out), 32'h00FF00);
    check("key_hit", 32'(sprite_hit_out), 32'h0);
    idle();
    check("opaque_rgb", 32'(rgb_out), 32'hFF0000);
    check("opaque_hit", 32'(sprite_hit_out), 32'h1);
    idle();
    check("flush_valid", 32'(pix_valid_out), 32'h0);

    // Mirroring
    facing_left = 1'b0;
    drive(1, 0, 0, 0, 24'h0);
    drive(0, 1, 100, 50, 24'h0);
    check("mirror_addr", 32'(rom_addr), 32'd240);

    // Edge clipping
    facing_left = 1'b1; mario_x = 10'd630; mario_y = 10'd60;
    drive(1, 0, 0, 0, 24'h0);
    drive(0, 1, 639, 60, 24'h0);
    check("clip_right_addr", 32'(rom_addr), 32'd251);
    drive(0, 1, 0, 61, 24'h112233);
    idle();
    check("clip_nowrap_rgb", 32'(rgb_out), 32'h112233);
    check("clip_nowrap_hit", 32'(sprite_hit_out), 32'h0);
    mario_x = 10'd100; mario_y = 10'd470;
    drive(1, 0, 0, 0, 24'h0);
    drive(0, 1, 100, 479, 24'h0);
    check("clip_bottom_addr", 32'(rom_addr), 32'd191);

    // Shadow latch
    mario_x = 10'd100; mario_y = 10'd50;
    drive(1, 0, 0, 0, 24'h0);
    mario_x = 10'd200;
    drive(0, 1, 102, 52, 24'hAAAAAA);
    drive(0, 1, 202, 52, 24'hBBBBBB);
    check("shadow_old_rgb", 32'(rgb_out), 32'h0000FF);
    check("shadow_old_hit", 32'(sprite_hit_out), 32'h1);
    idle();
    check("shadow_new_miss", 32'(rgb_out), 32'hBBBBBB);
    drive(1, 0, 0, 0, 24'h0);
    drive(0, 1, 202, 52, 24'hCCCCCC);
    idle();
    check("shadow_new_rgb", 32'(rgb_out), 32'h0000FF);

    // Animation
    moving = 1'b1;
    repeat (7) drive(1, 0, 0, 0, 24'h0);
    check("anim_7", 32'(rom_sel), 32'h0);
    drive(1, 0, 0, 0, 24'h0);
    check("anim_8", 32'(rom_sel), 32'h1);
    moving = 1'b0;
    idle();
    check("anim_hold", 32'(rom_sel), 32'h1);
    drive(1, 0, 0, 0, 24'h0);
    check("anim_stop", 32'(rom_sel), 32'h0);

    // Reset mid-line
    moving = 1'b1;
    repeat (8) drive(1, 0, 0, 0, 24'h0);
    drive(0, 1, 202, 52, 24'h123456);
    pix_valid_in = 1'b1; DrawX = 10'd203;
    #2 Reset_n = 1'b0;
    #1;
    check("rst_mid_rgb", 32'(rgb_out), 32'h0);
    check("rst_mid_valid", 32'(pix_valid_out), 32'h0);
    check("rst_mid_addr", 32'(rom_addr), 32'h0);
    check("rst_mid_sel", 32'(rom_sel), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    moving = 1'b0;
    drive(0, 1, 5, 5, 24'h445566);
    check("post_rst_lat1", 32'(pix_valid_out), 32'h0);
    check("post_rst_addr", 32'(rom_addr), 32'd221);
    idle();
    check("post_rst_lat2", 32'(pix_valid_out), 32'h1);

    // Random stream
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        r = $urandom_range(0, 3);
        mario_x = (r == 0) ? 10'($urandom_range(625, 639)) : 10'($urandom_range(0, 639));
        mario_y = (r == 1) ? 10'($urandom_range(465, 479)) : 10'($urandom_range(0, 479));
        facing_left = 1'($urandom_range(0, 1));
      end
      moving = ($urandom_range(0, 9) != 0);
      x = int'(mario_x) + $urandom_range(0, 48) - 8;
      y = int'(mario_y) + $urandom_range(0, 48) - 8;
      if ($urandom_range(0, 7) == 0) begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
      end
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 6) != 0, x, y, 24'($urandom));
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
